// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed A/D bus controller: widths,
// default strobe timing, FSM state encoding and the captured request payload.
package rtc_bus_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BUS_W  = 8;

  localparam int unsigned T_SU_DEF  = 2;
  localparam int unsigned T_PW_DEF  = 4;
  localparam int unsigned T_HD_DEF  = 2;
  localparam int unsigned T_GAP_DEF = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A_SU = 4'd1,
    S_A_PW = 4'd2,
    S_A_HD = 4'd3,
    S_D_SU = 4'd4,
    S_D_PW = 4'd5,
    S_D_HD = 4'd6,
    S_DONE = 4'd7,
    S_GAP  = 4'd8
  } state_t;

  // Transaction request latched when start is accepted
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  data;
  } req_t;

  // Largest of four timing constants, used to size the phase timer
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; zero_c flags the last cycle
// of the phase currently being timed.
module rtc_phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/rtc_ad_bus_ctrl.sv
// Runs one read or write cycle on the RTC multiplexed A/D bus: an address
// phase (address latched by a WR strobe) followed by a data phase (RD or WR
// strobe). All bus outputs are registered and aligned with the FSM state.
// Optional feature: define RTC_BUS_GAP_EN to insert a T_GAP-cycle chip-select
// high gap after DONE before the controller returns to IDLE.
module rtc_ad_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU  = T_SU_DEF,
  parameter int unsigned T_PW  = T_PW_DEF,
  parameter int unsigned T_HD  = T_HD_DEF,
  parameter int unsigned T_GAP = T_GAP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] direc,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic [BUS_W-1:0]  ad_out,
  input  logic [BUS_W-1:0]  ad_in,
  output logic              ad_oe,
  output logic              ad_sel,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n
);

  localparam int unsigned TW = $clog2(max4(T_SU, T_PW, T_HD, T_GAP) + 1);

  state_t         state;
  state_t         state_next;
  req_t           req_in;
  req_t           req_q;
  req_t           req_cur;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_zero;

  logic [BUS_W-1:0] ad_out_d;
  logic             ad_oe_d;
  logic             ad_sel_d;
  logic             cs_n_d;
  logic             rd_n_d;
  logic             wr_n_d;
  logic             busy_d;
  logic             done_d;

  assign req_in = {rw, direc, wdata};

  // While idle the request being accepted this edge is still on the inputs
  assign req_cur = (state == S_IDLE) ? req_in : req_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: each timed phase advances on the timer's last cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start)    state_next = S_A_SU;
      S_A_SU: if (tmr_zero) state_next = S_A_PW;
      S_A_PW: if (tmr_zero) state_next = S_A_HD;
      S_A_HD: if (tmr_zero) state_next = S_D_SU;
      S_D_SU: if (tmr_zero) state_next = S_D_PW;
      S_D_PW: if (tmr_zero) state_next = S_D_HD;
      S_D_HD: if (tmr_zero) state_next = S_DONE;
`ifdef RTC_BUS_GAP_EN
      S_DONE: state_next = S_GAP;
      S_GAP:  if (tmr_zero) state_next = S_IDLE;
`else
      S_DONE: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Phase timer reload with (length - 1) of the phase being entered
  always_comb begin
    tmr_load = (state_next != state);
    tmr_val  = '0;
    case (state_next)
      S_A_SU, S_D_SU: tmr_val = TW'(T_SU - 1);
      S_A_PW, S_D_PW: tmr_val = TW'(T_PW - 1);
      S_A_HD, S_D_HD: tmr_val = TW'(T_HD - 1);
      S_GAP:          tmr_val = TW'(T_GAP - 1);
      default:        tmr_val = '0;
    endcase
  end

  rtc_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // Capture the request when start is accepted; later input changes ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      req_q <= req_in;
    end
  end

  // Output decode from the state being entered, so registers track the state
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_sel_d = 1'b0;
    ad_out_d = '0;
    busy_d   = (state_next != S_IDLE);
    done_d   = 1'b0;
    case (state_next)
      S_A_SU, S_A_PW, S_A_HD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = BUS_W'(req_cur.addr);
        if (state_next == S_A_PW) wr_n_d = 1'b0;
      end
      S_D_SU, S_D_PW, S_D_HD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        if (req_cur.rw) begin
          ad_oe_d  = 1'b1;
          ad_out_d = req_cur.data;
        end
        if (state_next == S_D_PW) begin
          if (req_cur.rw) wr_n_d = 1'b0;
          else            rd_n_d = 1'b0;
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset releases the bus immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_out <= '0;
      ad_oe  <= 1'b0;
      ad_sel <= 1'b0;
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ad_out <= ad_out_d;
      ad_oe  <= ad_oe_d;
      ad_sel <= ad_sel_d;
      cs_n   <= cs_n_d;
      rd_n   <= rd_n_d;
      wr_n   <= wr_n_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Read data sampled on the final RD-strobe cycle while rd_n is still low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if ((state == S_D_PW) && tmr_zero && !req_q.rw) begin
      rdata <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_ad_bus_ctrl.sv
// Directed bench for rtc_ad_bus_ctrl: a table of transactions with expected
// per-cycle strobe masks, plus sequences for busy-start, mid-cycle reset,
// back-to-back starts and a minimum-timing instance.
module tb_rtc_ad_bus_ctrl;

  // Offsets are cycles after the edge that accepted start (bit n = cycle k+n)
  localparam logic [31:0] CS_M   = 32'h0001_FFFE;  // k+1..k+16
  localparam logic [31:0] DONE_M = 32'h0002_0000;  // k+17
  localparam logic [31:0] SEL_M  = 32'h0001_FE00;  // k+9..k+16
`ifdef RTC_BUS_GAP_EN
  localparam logic [31:0] BUSY_M  = 32'h001F_FFFE; // k+1..k+20
  localparam int          GAP_RUN = 5;             // DONE + 3 GAP + IDLE
`else
  localparam logic [31:0] BUSY_M  = 32'h0003_FFFE; // k+1..k+17
  localparam int          GAP_RUN = 2;             // DONE + IDLE
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start, rw;
  logic [6:0] direc;
  logic [7:0] wdata, ad_in;
  logic [7:0] rdata, ad_out;
  logic       busy, done, ad_oe, ad_sel, cs_n, rd_n, wr_n;

  logic       f_start, f_rw;
  logic [6:0] f_direc;
  logic [7:0] f_wdata, f_ad_in;
  logic [7:0] f_rdata, f_ad_out;
  logic       f_busy, f_done, f_ad_oe, f_ad_sel, f_cs_n, f_rd_n, f_wr_n;

  always #5 clk = ~clk;

  rtc_ad_bus_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .direc(direc),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .ad_out(ad_out),
    .ad_in(ad_in), .ad_oe(ad_oe), .ad_sel(ad_sel), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n)
  );

  rtc_ad_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .rw(f_rw), .direc(f_direc),
    .wdata(f_wdata), .rdata(f_rdata), .busy(f_busy), .done(f_done),
    .ad_out(f_ad_out), .ad_in(f_ad_in), .ad_oe(f_ad_oe), .ad_sel(f_ad_sel),
    .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n)
  );

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  adin;
    int          extra;      // offset of a stray start pulse, 0 = none
    logic [7:0]  exp_rdata;
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs[6];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one table entry and compare the recorded waveform masks
  task automatic run_vec(input int i);
    logic [31:0] m_cs, m_wr, m_rd, m_oe, m_sel, m_busy, m_done;
    logic [7:0]  a3, a11;
    m_cs = '0; m_wr = '0; m_rd = '0; m_oe = '0; m_sel = '0; m_busy = '0; m_done = '0;
    a3 = '0; a11 = '0;
    rw = vecs[i].rw; direc = vecs[i].addr; wdata = vecs[i].wd; ad_in = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    rw = ~rw; direc = ~direc; wdata = ~wdata;
    for (int o = 1; o < 32; o++) begin
      m_cs[o]   = ~cs_n;
      m_wr[o]   = ~wr_n;
      m_rd[o]   = ~rd_n;
      m_oe[o]   = ad_oe;
      m_sel[o]  = ad_sel;
      m_busy[o] = busy;
      m_done[o] = done;
      if (o == 3)  a3  = ad_out;
      if (o == 11) a11 = ad_out;
      start = (o == vecs[i].extra);
      ad_in = rd_n ? 8'hFF : vecs[i].adin;
      tick();
    end
    start = 1'b0;
    check($sformatf("v%0d_cs", i),    m_cs,   CS_M);
    check($sformatf("v%0d_wr", i),    m_wr,   vecs[i].exp_wr);
    check($sformatf("v%0d_rd", i),    m_rd,   vecs[i].exp_rd);
    check($sformatf("v%0d_oe", i),    m_oe,   vecs[i].exp_oe);
    check($sformatf("v%0d_sel", i),   m_sel,  SEL_M);
    check($sformatf("v%0d_busy", i),  m_busy, BUSY_M);
    check($sformatf("v%0d_done", i),  m_done, DONE_M);
    check($sformatf("v%0d_addr", i),  {24'h0, a3}, {25'h0, vecs[i].addr});
    if (vecs[i].rw) check($sformatf("v%0d_wdata", i), {24'h0, a11}, {24'h0, vecs[i].wd});
    check($sformatf("v%0d_rdata", i), {24'h0, rdata}, {24'h0, vecs[i].exp_rdata});
  endtask

  initial begin
    int dcount, run, nruns, run0, run1;
    logic seen_low;
    logic [31:0] f_m_rd, f_m_wr, f_m_done;

    //            rw    addr   wd     adin   extra rdata  wr_mask       rd_mask       oe_mask
    vecs[0] = '{1'b0, 7'h4A, 8'h00, 8'h59, 0, 8'h59, 32'h0000_0078, 32'h0000_7800, 32'h0000_01FE};
    vecs[1] = '{1'b1, 7'h45, 8'h3A, 8'h00, 0, 8'h59, 32'h0000_7878, 32'h0000_0000, 32'h0001_FFFE};
    vecs[2] = '{1'b1, 7'h45, 8'h3A, 8'h00, 5, 8'h59, 32'h0000_7878, 32'h0000_0000, 32'h0001_FFFE};
    vecs[3] = '{1'b0, 7'h00, 8'h00, 8'h00, 0, 8'h00, 32'h0000_0078, 32'h0000_7800, 32'h0000_01FE};
    vecs[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 0, 8'h00, 32'h0000_7878, 32'h0000_0000, 32'h0001_FFFE};
    vecs[5] = '{1'b0, 7'h7F, 8'h00, 8'hA5, 7, 8'hA5, 32'h0000_0078, 32'h0000_7800, 32'h0000_01FE};

    reset = 1'b1;
    start = 1'b0; rw = 1'b0; direc = '0; wdata = '0; ad_in = 8'hFF;
    f_start = 1'b0; f_rw = 1'b0; f_direc = '0; f_wdata = '0; f_ad_in = 8'hFF;
    tick(); tick();
    check("reset_state", {9'h0, rdata, busy, done, ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n},
          {9'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    check("fast_reset_state",
          {9'h0, f_rdata, f_busy, f_done, f_ad_out, f_ad_oe, f_ad_sel, f_cs_n, f_rd_n, f_wr_n},
          {9'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset asserted during the address WR strobe releases the bus at once
    rw = 1'b1; direc = 7'h12; wdata = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("rst_pre_wr_low", {31'h0, wr_n}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("rst_cs_n",  {31'h0, cs_n},  32'h1);
    check("rst_wr_n",  {31'h0, wr_n},  32'h1);
    check("rst_ad_oe", {31'h0, ad_oe}, 32'h0);
    check("rst_busy",  {31'h0, busy},  32'h0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    check("rst_after_idle", {29'h0, busy, cs_n, wr_n}, {29'h0, 1'b0, 1'b1, 1'b1});

    // start held high: three back-to-back transactions
    rw = 1'b0; direc = 7'h21; ad_in = 8'h00;
    start = 1'b1;
    dcount = 0; run = 0; nruns = 0; run0 = 0; run1 = 0; seen_low = 1'b0;
    for (int c = 0; c < 150 && dcount < 3; c++) begin
      tick();
      if (!cs_n) begin
        if (seen_low && run > 0) begin
          if (nruns == 0) run0 = run;
          else if (nruns == 1) run1 = run;
          nruns++;
        end
        run = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        run++;
      end
      if (done) begin
        dcount++;
        if (dcount == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_done_count", dcount, 3);
    check("b2b_gap_count",  nruns, 2);
    check("b2b_gap0",       run0, GAP_RUN);
    check("b2b_gap1",       run1, GAP_RUN);
    for (int c = 0; c < 25; c++) tick();
    check("b2b_idle", {30'h0, busy, cs_n}, {30'h0, 1'b0, 1'b1});

    // Minimum timing instance: read completes with done at k+7
    f_rw = 1'b0; f_direc = 7'h2B;
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    f_m_rd = '0; f_m_wr = '0; f_m_done = '0;
    for (int o = 1; o < 16; o++) begin
      f_m_rd[o]   = ~f_rd_n;
      f_m_wr[o]   = ~f_wr_n;
      f_m_done[o] = f_done;
      f_ad_in = f_rd_n ? 8'hFF : 8'h6C;
      tick();
    end
    check("fast_done", f_m_done, 32'h0000_0080);
    check("fast_rd",   f_m_rd,   32'h0000_0020);
    check("fast_wr",   f_m_wr,   32'h0000_0004);
    check("fast_rdata", {24'h0, f_rdata}, 32'h0000_006C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
